mem_controller: RTL and testbench

Single-port memory controller on the downstream side of the CPU's `memory_bus`. It accepts one-cycle `dispatch_read`/`dispatch_write` pulses with byte, halfword or word width, and drives a 32-bit, byte-enabled, fixed-latency BRAM. It returns little-endian, zero-extended read data; the CPU performs any sign extension. Accesses that cross a 32-bit word boundary are split into two BRAM operations transparently.

---
 rtl/mem_controller.sv | 142 ++++++++++++++
 tb/tb_mem_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Byte/halfword/word CPU requests onto a 32-bit byte-enabled BRAM; word-crossing accesses become two BRAM operations.
// Latency: writes 2-3 cycles, reads BRAM_LATENCY+2/+3; no backpressure, a dispatch while busy is dropped.
module mem_controller #(
    parameter int ADDR_WIDTH   = 14,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  dispatch_read,
    input  logic                  dispatch_write,
    input  logic [31:0]           addr,
    input  logic [1:0]            mem_width,
    input  logic [31:0]           write_data,
    output logic                  busy,
    output logic [31:0]           read_data,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_din,
    output logic [3:0]            bram_we,
    output logic                  bram_en,
    input  logic [31:0]           bram_dout
);
    localparam int CW = $clog2(BRAM_LATENCY + 2);
    localparam logic [CW-1:0] LAT_W0 = CW'(BRAM_LATENCY);
    localparam logic [CW-1:0] LAT_W1 = CW'(BRAM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ISSUE2, WAIT} state_t;
    state_t state;

    logic [1:0]            req_off;
    logic [3:0]            req_size_mask;
    logic                  req_split;
    logic [ADDR_WIDTH-1:0] req_waddr;
    logic [63:0]           req_lanes;
    logic [7:0]            req_we;

    logic                  is_write;
    logic                  split;
    logic [1:0]            off;
    logic [3:0]            size_mask;
    logic [ADDR_WIDTH-1:0] waddr1;
    logic [31:0]           din1;
    logic [3:0]            we1;
    logic [31:0]           word0;
    logic [CW-1:0]         cnt;
    logic [63:0]           rd_pair;
    logic [31:0]           rd_shift;
    logic [31:0]           rd_result;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];
    assign busy = !rst_in && (dispatch_read || dispatch_write || state != IDLE);

    always_comb begin
        req_off = addr[1:0];
        case (mem_width)
            2'd0:    req_size_mask = 4'b0001;
            2'd1:    req_size_mask = 4'b0011;
            default: req_size_mask = 4'b1111;
        endcase
        req_waddr = addr[ADDR_WIDTH+1:2];
        req_lanes = {32'b0, write_data} << {req_off, 3'b000};
        req_we    = {4'b0, req_size_mask} << req_off;
        // Any enable landing in the upper half means the access crosses into the next word.
        req_split = |req_we[7:4];
    end

    always_comb begin
        rd_pair   = split ? {bram_dout, word0} : {32'b0, bram_dout};
        rd_shift  = 32'(rd_pair >> {off, 3'b000});
        rd_result = rd_shift & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                {8{size_mask[1]}}, {8{size_mask[0]}}};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            bram_en   <= 1'b0;
            bram_we   <= 4'b0;
            bram_addr <= '0;
            bram_din  <= 32'b0;
            read_data <= 32'b0;
            is_write  <= 1'b0;
            split     <= 1'b0;
            off       <= 2'b0;
            size_mask <= 4'b0;
            waddr1    <= '0;
            din1      <= 32'b0;
            we1       <= 4'b0;
            word0     <= 32'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dispatch_read || dispatch_write) begin
                        is_write  <= dispatch_write;
                        split     <= req_split;
                        off       <= req_off;
                        size_mask <= req_size_mask;
                        waddr1    <= req_waddr + ADDR_WIDTH'(1);
                        din1      <= req_lanes[63:32];
                        we1       <= dispatch_write ? req_we[7:4] : 4'b0;
                        cnt       <= '0;
                        bram_en   <= 1'b1;
                        bram_addr <= req_waddr;
                        bram_din  <= req_lanes[31:0];
                        bram_we   <= dispatch_write ? req_we[3:0] : 4'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt     <= cnt + CW'(1);
                    bram_en <= split;
                    bram_we <= split ? we1 : 4'b0;
                    if (split) begin
                        bram_addr <= waddr1;
                        bram_din  <= din1;
                        state     <= ISSUE2;
                    end else begin
                        state <= is_write ? IDLE : WAIT;
                    end
                end
                ISSUE2: begin
                    cnt     <= cnt + CW'(1);
                    bram_en <= 1'b0;
                    bram_we <= 4'b0;
                    // With BRAM_LATENCY of 1 the first word already returns here.
                    if (cnt == LAT_W0) word0 <= bram_dout;
                    state <= is_write ? IDLE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAT_W0) word0 <= bram_dout;
                    if (cnt == (split ? LAT_W1 : LAT_W0)) begin
                        read_data <= rd_result;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller on a 16-word BRAM model: BRAM strobes and read results are checked against queued expectations.
module tb_mem_controller;
    localparam int AW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          dispatch_read;
    logic          dispatch_write;
    logic [31:0]   addr;
    logic [1:0]    mem_width;
    logic [31:0]   write_data;
    logic          busy;
    logic [31:0]   read_data;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic [3:0]    bram_we;
    logic          bram_en;
    logic [31:0]   bram_dout;

    always #5 clk = ~clk;

    mem_controller #(.ADDR_WIDTH(AW), .BRAM_LATENCY(LAT)) dut (
        .clk_in(clk), .rst_in(rst_in), .dispatch_read(dispatch_read),
        .dispatch_write(dispatch_write), .addr(addr), .mem_width(mem_width),
        .write_data(write_data), .busy(busy), .read_data(read_data),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .bram_en(bram_en), .bram_dout(bram_dout)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  we;
        logic [31:0] din;
    } wr_t;

    wr_t         wq[$];
    logic [3:0]  rq[$];
    logic [31:0] rdq[$];
    logic [7:0]  ref_mem[64];
    logic [31:0] bram[16];
    logic [31:0] pipe0;
    logic [31:0] last_rd = 32'b0;
    wr_t         mon_e;
    bit          rw;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] we);
        logic [31:0] m;
        for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{we[j]}};
        return m;
    endfunction

    always @(posedge clk) begin
        if (bram_en)
            for (int j = 0; j < 4; j++)
                if (bram_we[j]) bram[bram_addr][8*j +: 8] <= bram_din[8*j +: 8];
        pipe0     <= bram_en ? bram[bram_addr] : 32'hBAD0BAD0;
        bram_dout <= pipe0;
    end

    always @(negedge clk) begin
        if (bram_en && bram_we != 4'b0) begin
            if (wq.size() == 0) chk("wr_extra", 64'(bram_we), 64'd0);
            else begin
                mon_e = wq.pop_front();
                chk("wr_addr", 64'(bram_addr), 64'(mon_e.a));
                chk("wr_we", 64'(bram_we), 64'(mon_e.we));
                chk("wr_din", 64'(bram_din & lanes(mon_e.we)), 64'(mon_e.din));
            end
        end else if (bram_en) begin
            if (rq.size() == 0) chk("rd_extra", 64'(bram_en), 64'd0);
            else chk("rd_addr", 64'(bram_addr), 64'(rq.pop_front()));
        end else if (bram_we != 4'b0) begin
            chk("we_noen", 64'(bram_we), 64'd0);
        end
    end

    task automatic op(input bit wr, input bit rd, input logic [31:0] a, input logic [1:0] w,
                      input logic [31:0] d, input bit intrude);
        int s, off, exp_cyc, cyc;
        bit sp;
        logic [3:0] we0, we1, wa0;
        logic [31:0] din0, din1, exp_rd;
        wr_t e;
        s   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        sp  = (off + s) > 4;
        wa0 = a[5:2];
        we0 = 4'b0; we1 = 4'b0; din0 = 32'b0; din1 = 32'b0; exp_rd = 32'b0;
        if (wr) begin
            for (int i = 0; i < s; i++) begin
                if (off + i < 4) begin
                    we0[off+i] = 1'b1;
                    din0[8*(off+i) +: 8] = d[8*i +: 8];
                end else begin
                    we1[off+i-4] = 1'b1;
                    din1[8*(off+i-4) +: 8] = d[8*i +: 8];
                end
                ref_mem[(int'(a[5:0]) + i) % 64] = d[8*i +: 8];
            end
            e.a = wa0; e.we = we0; e.din = din0; wq.push_back(e);
            if (sp) begin
                e.a = wa0 + 4'd1; e.we = we1; e.din = din1; wq.push_back(e);
            end
            exp_cyc = sp ? 3 : 2;
        end else begin
            for (int i = 0; i < s; i++) exp_rd[8*i +: 8] = ref_mem[(int'(a[5:0]) + i) % 64];
            rq.push_back(wa0);
            if (sp) rq.push_back(wa0 + 4'd1);
            rdq.push_back(exp_rd);
            exp_cyc = sp ? 3 + LAT : 2 + LAT;
        end
        addr = a; mem_width = w; write_data = d;
        dispatch_read = rd; dispatch_write = wr;
        #1;
        chk("busy_c0", 64'(busy), 64'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            dispatch_read  = 1'b0;
            dispatch_write = 1'b0;
            if (intrude && cyc == 2) begin
                dispatch_write = 1'b1;
                addr = 32'h20; mem_width = 2'd2; write_data = 32'hFFFF_FFFF;
            end
            #1;
        end while (busy && cyc < 40);
        chk("done_cyc", 64'(cyc), 64'(exp_cyc));
        if (wr) chk("rd_hold", 64'(read_data), 64'(last_rd));
        else begin
            exp_rd = rdq.pop_front();
            chk("rdata", 64'(read_data), 64'(exp_rd));
            last_rd = exp_rd;
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            ref_mem[k] = 8'(k * 7 + 3);
            bram[k / 4][8*(k % 4) +: 8] = 8'(k * 7 + 3);
        end
        rst_in = 1'b1; dispatch_read = 1'b0; dispatch_write = 1'b0;
        addr = 32'b0; mem_width = 2'b0; write_data = 32'b0;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        #1;
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_rdata0", 64'(read_data), 64'd0);
        chk("rst_en", 64'(bram_en), 64'd0);
        chk("rst_we", 64'(bram_we), 64'd0);
        chk("rst_addr", 64'(bram_addr), 64'd0);
        chk("rst_din", 64'(bram_din), 64'd0);

        op(1, 0, 32'h10, 2'd2, 32'hDEAD_BEEF, 0);
        op(0, 1, 32'h10, 2'd2, 32'h0, 0);
        op(1, 0, 32'h13, 2'd0, 32'h0000_00AB, 0);
        op(0, 1, 32'h12, 2'd1, 32'h0, 0);
        op(1, 0, 32'h06, 2'd2, 32'h1122_3344, 0);
        op(0, 1, 32'h06, 2'd2, 32'h0, 0);
        op(1, 0, 32'h3F, 2'd1, 32'h0000_C0DE, 0);
        op(0, 1, 32'h3F, 2'd1, 32'h0, 0);
        op(1, 1, 32'h08, 2'd2, 32'hCAFE_F00D, 0);
        op(0, 1, 32'h08, 2'd2, 32'h0, 0);
        op(0, 1, 32'h30, 2'd3, 32'h0, 1);
        op(0, 1, 32'h20, 2'd2, 32'h0, 0);

        // Reset lands in cycle 2 of an unsplit read.
        addr = 32'h10; mem_width = 2'd2; dispatch_read = 1'b1;
        rq.push_back(4'h4);
        #1;
        @(posedge clk); #1 dispatch_read = 1'b0;
        @(posedge clk); #1 rst_in = 1'b1;
        #1 chk("busy_rst", 64'(busy), 64'd0);
        @(posedge clk); #1 rst_in = 1'b0;
        #1;
        chk("rst_rdata", 64'(read_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        last_rd = 32'b0;
        repeat (6) @(posedge clk);
        #2;
        op(0, 1, 32'h10, 2'd2, 32'h0, 0);

        for (int n = 0; n < 12; n++) begin
            rw = ($urandom_range(0, 1) == 1);
            op(rw, !rw, 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), $urandom, 0);
        end

        repeat (3) @(posedge clk);
        chk("wq_left", 64'(wq.size()), 64'd0);
        chk("rq_left", 64'(rq.size()), 64'd0);
        chk("rdq_left", 64'(rdq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
